// File: rtl/unpack_metadata.sv
// unpack_metadata: receive-side metadata unpacker for the radar sample path.
// Strips the metadata slice carried in the high bits of each sample, extends the
// remaining sample bits back to full width, and reassembles the metadata word
// one slice per accepted strobe after an init.
module unpack_metadata #(
    parameter int unsigned data_width      = 16,
    parameter int unsigned data_width_used = 12,
    parameter int unsigned meta_data_width = 448,
    parameter bit          sign_extend     = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       init,
    input  logic [data_width-1:0]      data_in,
    input  logic                       strobe_in,
    output logic [data_width-1:0]      data_out,
    output logic                       strobe_out,
    output logic [meta_data_width-1:0] meta_data,
    output logic                       meta_valid,
    output logic                       collecting
);

    localparam int unsigned pack_width = data_width - data_width_used;
    localparam int unsigned n_slices   = meta_data_width / pack_width;
    localparam int unsigned cnt_width  = (n_slices > 1) ? $clog2(n_slices) : 1;
    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(n_slices - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    state_e                     r_state, w_state_d;
    logic [cnt_width-1:0]       r_cnt, w_cnt_d;
    logic [meta_data_width-1:0] r_shreg, w_shreg_d;
    logic [meta_data_width-1:0] r_meta, w_meta_d;
    logic                       r_meta_valid, w_meta_valid_d;
    logic [data_width-1:0]      r_data_out, w_data_out_d;
    logic                       r_strobe_out, w_strobe_out_d;
    logic                       r_collecting;

    logic                       w_accept;
    logic [pack_width-1:0]      w_slice;
    logic [data_width-1:0]      w_ext;
    logic [meta_data_width-1:0] w_shifted;

    // init wins over a coincident strobe: that sample is dropped, not counted.
    assign w_accept  = enable & strobe_in & ~init;
    assign w_slice   = data_in[data_width-1:data_width_used];
    assign w_shifted = {w_slice, r_shreg[meta_data_width-1:pack_width]};

    // Strip the slice bits and extend the sample proper back to full width.
    always_comb begin
        w_ext = '0;
        w_ext[data_width_used-1:0] = data_in[data_width_used-1:0];
        if (sign_extend) begin
            w_ext[data_width-1:data_width_used] = {pack_width{data_in[data_width_used-1]}};
        end
    end

    // Next-state logic for the collection FSM, sample path and metadata outputs.
    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_shreg_d      = r_shreg;
        w_meta_d       = r_meta;
        w_meta_valid_d = 1'b0;
        w_data_out_d   = r_data_out;
        w_strobe_out_d = 1'b0;

        // Samples pass through in every state.
        if (w_accept) begin
            w_data_out_d   = w_ext;
            w_strobe_out_d = 1'b1;
        end

        if (init) begin
            // Restart from any state; a partial word is discarded silently.
            w_state_d = StCollect;
            w_cnt_d   = '0;
            w_shreg_d = '0;
        end else if (w_accept && (r_state == StCollect)) begin
            w_shreg_d = w_shifted;
            if (r_cnt == last_cnt) begin
                w_meta_d       = w_shifted;
                w_meta_valid_d = 1'b1;
                w_state_d      = StDone;
                w_cnt_d        = '0;
            end else begin
                w_cnt_d = r_cnt + cnt_width'(1);
            end
        end
    end

    // State and output registers; synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_shreg      <= '0;
            r_meta       <= '0;
            r_meta_valid <= 1'b0;
            r_data_out   <= '0;
            r_strobe_out <= 1'b0;
            r_collecting <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_shreg      <= w_shreg_d;
            r_meta       <= w_meta_d;
            r_meta_valid <= w_meta_valid_d;
            r_data_out   <= w_data_out_d;
            r_strobe_out <= w_strobe_out_d;
            r_collecting <= (w_state_d == StCollect);
        end
    end

    assign data_out   = r_data_out;
    assign strobe_out = r_strobe_out;
    assign meta_data  = r_meta;
    assign meta_valid = r_meta_valid;
    assign collecting = r_collecting;

endmodule

// File: tb/tb_unpack_metadata.sv
// Testbench for unpack_metadata: directed steps drive the inputs, expected
// samples are queued on acceptance and checked as strobe_out appears.
module tb_unpack_metadata;

    localparam int DW = 16;
    localparam int MW = 448;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          init;
    logic [DW-1:0] data_in;
    logic          strobe_in;
    logic [DW-1:0] data_out;
    logic          strobe_out;
    logic [MW-1:0] meta_data;
    logic          meta_valid;
    logic          collecting;

    unpack_metadata dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .init       (init),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .meta_data  (meta_data),
        .meta_valid (meta_valid),
        .collecting (collecting)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          pulse;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_item;
    logic [MW-1:0] exp_meta;
    logic [MW-1:0] meta_model;
    logic          mon_en;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ext12(input logic [DW-1:0] d);
        return {{4{d[11]}}, d[11:0]};
    endfunction

    // Drive one cycle of inputs, queue the expected output if it is accepted,
    // and return #1 after the edge that applies them.
    task automatic step(input logic rst, input logic en, input logic stb, input logic ini,
                        input logic [DW-1:0] din, input logic pulse);
        exp_t e;
        reset     = rst;
        enable    = en;
        strobe_in = stb;
        init      = ini;
        data_in   = din;
        if (!rst && en && stb && !ini) begin
            e.data  = ext12(din);
            e.pulse = pulse;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        if (rst) meta_model = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Scoreboard: pop on every strobe_out, track meta_data against its model.
    always @(negedge clock) begin
        if (mon_en) begin
            if (strobe_out) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", MW'(strobe_out), MW'(0));
                end else begin
                    mon_item = sb.pop_front();
                    chk("data_out", MW'(data_out), MW'(mon_item.data));
                    chk("meta_valid", MW'(meta_valid), MW'(mon_item.pulse));
                    if (mon_item.pulse) begin
                        meta_model = exp_meta;
                        chk("collecting_at_pulse", MW'(collecting), MW'(0));
                    end
                end
            end else begin
                chk("meta_valid_idle", MW'(meta_valid), MW'(0));
            end
            chk("meta_data", meta_data, meta_model);
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        mon_en     = 1'b0;
        meta_model = '0;
        exp_meta   = '0;
        reset      = 1'b1;
        enable     = 1'b0;
        init       = 1'b0;
        strobe_in  = 1'b0;
        data_in    = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_data_out", MW'(data_out), MW'(0));
        chk("rst_strobe_out", MW'(strobe_out), MW'(0));
        chk("rst_meta_data", meta_data, MW'(0));
        chk("rst_meta_valid", MW'(meta_valid), MW'(0));
        chk("rst_collecting", MW'(collecting), MW'(0));
        mon_en = 1'b1;

        // Pass-through with no init: sign extension of the sample bits.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'hF800, 1'b0);
        chk("pass_F800", MW'(data_out), MW'(16'hF800));
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h57FF, 1'b0);
        chk("pass_57FF", MW'(data_out), MW'(16'h07FF));
        idle(3);

        // Full record, back-to-back strobes, slice k = k mod 16.
        for (int k = 0; k < 112; k++) exp_meta[k*4 +: 4] = 4'(k % 16);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("collecting_after_init", MW'(collecting), MW'(1));
        for (int k = 0; k < 112; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'(k % 16), 12'(k)}, k == 111);
        chk("collecting_after_done", MW'(collecting), MW'(0));
        chk("meta_lo_nibble", MW'(meta_data[3:0]), MW'(4'h0));
        chk("meta_hi_nibble", MW'(meta_data[447:444]), MW'(4'hF));
        for (int k = 112; k < 116; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'h9, 12'(k)}, 1'b0);
        idle(2);

        // Same record with sparse strobes and an enable-low gap.
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        for (int k = 0; k < 112; k++) begin
            idle(2);
            if (k == 40) begin
                for (int j = 0; j < 5; j++)
                    step(1'b0, 1'b0, 1'b1, 1'b0, {4'hE, 12'h321}, 1'b0);
            end
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'(k % 16), 12'(k + 2000)}, k == 111);
        end
        idle(2);

        // Aborted record after 50 slices, then a full all-ones record.
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        for (int k = 0; k < 50; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'h5, 12'(k * 7)}, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        chk("collecting_restart", MW'(collecting), MW'(1));
        exp_meta = '1;
        for (int k = 0; k < 112; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'hF, 12'(k * 3)}, k == 111);
        idle(2);

        // init coincident with a strobe: that sample is dropped, next is slice 0.
        step(1'b0, 1'b1, 1'b1, 1'b1, {4'h3, 12'h123}, 1'b0);
        chk("init_strobe_dropped", MW'(strobe_out), MW'(0));
        for (int k = 0; k < 112; k++) exp_meta[k*4 +: 4] = (k == 0) ? 4'hA : 4'(k % 16);
        for (int k = 0; k < 112; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {((k == 0) ? 4'hA : 4'(k % 16)), 12'(k + 500)},
                 k == 111);
        chk("meta_slice0_A", MW'(meta_data[3:0]), MW'(4'hA));
        idle(2);

        // Reset at slice 60, then pass-through with no pulse.
        step(1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
        for (int k = 0; k < 60; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'(k % 16), 12'(k)}, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, {4'hC, 12'h060}, 1'b0);
        chk("mid_rst_data_out", MW'(data_out), MW'(0));
        chk("mid_rst_strobe_out", MW'(strobe_out), MW'(0));
        chk("mid_rst_meta_data", meta_data, MW'(0));
        chk("mid_rst_meta_valid", MW'(meta_valid), MW'(0));
        chk("mid_rst_collecting", MW'(collecting), MW'(0));
        for (int k = 0; k < 120; k++)
            step(1'b0, 1'b1, 1'b1, 1'b0, {4'(k % 16), 12'(k + 3000)}, 1'b0);
        idle(3);

        chk("scoreboard_drained", MW'(sb.size()), MW'(0));
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unpack_metadata.md
# unpack_metadata

Receive-side counterpart of the metadata packer in the radar sample path. Consumes a sample stream whose unused high-order bits carry a metadata word, 4 bits per sample starting at the first sample after `init`. Outputs the samples with the metadata bits stripped (sign-extended to full width) and reassembles the metadata word, flagging it with a one-cycle valid pulse. Sits at the far end of any link carrying packed samples, e.g. loopback/verification paths and host-side FPGA decode.

## Interface
- `data_width`, 16, width of the incoming and outgoing sample words.
- `data_width_used`, 12, sample bits proper; must be less than `data_width`.
- `meta_data_width`, 448, metadata word width; must be an integer multiple of `pack_width`.
- `sign_extend`, 1, 1: `data_out` is sign-extended from bit `data_width_used-1`; 0: zero-extended.
- Derived: `pack_width = data_width - data_width_used` (4 by default); `n_slices = meta_data_width / pack_width` (112 by default).

- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  qualifies `strobe_in`; when low, input strobes are ignored and all state holds.
- `init`  in  1  start of record; the next accepted strobe carries slice 0.
- `data_in`  in  `data_width`  packed sample, `{slice, sample[data_width_used-1:0]}`.
- `strobe_in`  in  1  `data_in` valid this cycle.
- `data_out`  out  `data_width`  stripped, extended sample.
- `strobe_out`  out  1  `data_out` valid; 1-cycle pulse per accepted input.
- `meta_data`  out  `meta_data_width`  last completely reassembled metadata word.
- `meta_valid`  out  1  1-cycle pulse: `meta_data` has just been updated.
- `collecting`  out  1  high while in COLLECT.

## Operation
- Reset: state IDLE, slice counter 0, shift register 0, `data_out`=0, `strobe_out`=0, `meta_data`=0, `meta_valid`=0.
- Accepted strobe: `enable & strobe_in & ~init`.
- Sample path, every accepted strobe in any state: `data_out <= ext(data_in[data_width_used-1:0])`, `strobe_out <= 1`. Otherwise `strobe_out <= 0`, and `data_out` holds its value.
- States:
  - IDLE: reached from reset. Samples pass through; high bits are ignored.
  - COLLECT: entered on `init` from any state. On entry, the counter and shift register are cleared. Each accepted strobe shifts in `slice = data_in[data_width-1:data_width_used]`: `shreg <= {slice, shreg[meta_data_width-1:pack_width]}` and increments the counter. This places slice k at bits `[k*pack_width +: pack_width]` after the final shift. When the strobe with counter == `n_slices-1` is accepted: `meta_data <= {slice, shreg[meta_data_width-1:pack_width]}`, `meta_valid <= 1`, state goes to DONE, counter returns to 0.
  - DONE: samples pass through; high bits are ignored (the packer sends zeros). Only `init` or `reset` leaves DONE.
- `init` has priority over a strobe in the same cycle. That sample is dropped (`strobe_out` = 0 next cycle) and is not counted, mirroring the packer, which discards it.
- `init` while in COLLECT: the partial word is discarded, collection restarts, no `meta_valid` pulse, and `meta_data` is unchanged.
- `enable` low mid-collection: the counter and shift register freeze; collection resumes when `enable` returns.
- `reset` mid-collection: returns to IDLE with all outputs at reset values. Collection needs a fresh `init`.
- `meta_data` changes only at completion; it is stable at all other times.
- `collecting` is registered and equals (state == COLLECT).

## Timing
- Latency is 1 clock: an input accepted at edge t gives `data_out`/`strobe_out` valid after edge t, i.e. in cycle t+1.
- `meta_valid` is asserted in the same cycle as the `strobe_out` of the sample carrying slice `n_slices-1`.
- `collecting` rises the cycle after `init` and falls in the same cycle `meta_valid` pulses.
- Back-to-back strobes (every cycle) are supported with no bubbles. Inputs have no backpressure.

## Test plan
- Reset then a stream with no `init`: `data_in`=16'hF800 gives `data_out`=16'hF800 (sign-extended 12'h800); `data_in`=16'h57FF gives 16'h07FF. `meta_valid` never pulses and `meta_data` stays 0.
- `init`, then 112 strobes where slice k = k mod 16 and sample = k: `meta_valid` pulses once, aligned with the 112th `strobe_out`. `meta_data` = repeating nibbles 0..F, with bits [3:0]=0 and [447:444]=F. Outputs 113+ pass with no further pulse.
- Same stream with `strobe_in` asserted every third cycle and `enable` low for 5 cycles mid-stream (strobes dropped while low): the identical `meta_data` results, and its single pulse is aligned with the last accepted sample.
- `init` after 50 slices, then a full 112-slice record of all-ones nibbles: no pulse for the aborted record, then `meta_data` = all ones. Between the abort and completion, `meta_data` keeps its prior value.
- `init` coincident with `strobe_in`: no `strobe_out` for that sample, and the next strobe is slice 0 (checked via a distinct slice-0 nibble 4'hA at `meta_data[3:0]`).
- `reset` asserted at slice 60: all outputs 0 the next cycle and `collecting`=0. Following strobes pass through with no `meta_valid` until a new `init`.
